serial_endpoint: RTL and testbench
==================================

# serial_endpoint

Device-side end of the processor serial port. Accepts bytes the processor writes, using a `serial_wren_out`/`serial_ready_in` style handshake, and serialises them onto a UART TX line. Deserialises a UART RX line into bytes the processor reads, using a `serial_valid_in`/`serial_rden_out` style handshake. Sits at top level between the processor's serial pins and the board UART pins; each direction is buffered by a small FIFO.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); minimum 4.
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, minimum 2.
- `clock` in 1: single clock, all logic on posedge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `uart_rx_in` in 1: asynchronous serial input, idle high.
- `uart_tx_out` out 1: serial output, idle high.
- `proc_rdata` out 8: head of RX FIFO; connects to processor `serial_in`.
- `proc_rvalid` out 1: RX FIFO non-empty; connects to `serial_valid_in`.
- `proc_rden` in 1: pop RX head; driven by `serial_rden_out`.
- `proc_wdata` in 8: byte to transmit; driven by `serial_out`.
- `proc_wren` in 1: push `proc_wdata`; driven by `serial_wren_out`.
- `proc_wready` out 1: TX FIFO not full; connects to `serial_ready_in`.
- `rx_overrun_out` out 1: sticky; a received byte was dropped because the RX FIFO was full.
- `rx_frame_err_out` out 1: sticky; bad stop bit (or bad parity) seen.

## Operation
- **Reset values:**
  - `uart_tx_out`=1.
  - `proc_rvalid`=0, `proc_wready`=1.
  - `proc_rdata`=0.
  - Both sticky flags=0.
  - FIFOs empty; both FSMs IDLE.
- **Processor write:**
  - `proc_wren`=1 while `proc_wready`=1 pushes the byte at the clock edge.
  - `proc_wren` while not ready: the byte is dropped, no state changes.
- **Processor read:**
  - `proc_rden`=1 while `proc_rvalid`=1 pops the head at the edge.
  - `proc_rden` while empty is ignored.
  - `proc_rdata` is first-word-fall-through, registered-array output.
- **Simultaneous push and pop on a full FIFO:** both succeed; the count stays the same.
- **TX FSM:** states IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - In IDLE with the TX FIFO non-empty, it pops at the next edge and enters START.
  - Each state holds for `CLKS_PER_BIT` cycles, counted by a down-counter from `CLKS_PER_BIT-1`.
  - DATA sends 8 bits LSB first, tracked by a 3-bit counter.
  - STOP drives 1, then returns to IDLE. Back-to-back frames have no extra idle cycle.
- **RX path:** `uart_rx_in` passes through a 2-flop synchronizer.
  - RX FSM states: IDLE → START → DATA → [PARITY] → STOP.
  - IDLE: a synchronized low starts a wait of `CLKS_PER_BIT/2` cycles, then the start bit is re-sampled. If it is high (glitch), return to IDLE with no error.
  - Data bits are sampled every `CLKS_PER_BIT` cycles from the mid-start point, LSB first.
  - Stop bit sampled 0: byte discarded, `rx_frame_err_out` set.
  - Good frame: push at the stop sample. If the RX FIFO is full and not popped that cycle, the byte is discarded and `rx_overrun_out` is set.
- Sticky flags clear only on reset.

## Timing
- **TX latency:**
  - Write accepted at edge N.
  - FSM pops at edge N+1; `uart_tx_out` falls after N+1.
  - Frame length is 10×`CLKS_PER_BIT` cycles (11× with parity).
- **`proc_wready`** deasserts in the cycle after the push that fills the FIFO.
- **RX latency:** `proc_rvalid` rises 1 cycle after the stop-bit sample edge.
- **Reset mid-frame:** the TX line returns high immediately (asynchronously). A partial RX byte is lost, with no flag set.

## Configuration
- `SERIAL_ENDPOINT_PARITY_EN` defined: even parity is added after the data bits on both TX and RX.
  - TX sends XOR of the data bits.
  - RX parity mismatch discards the byte and sets `rx_frame_err_out`.
- Undefined: plain 8N1; no PARITY state exists.

## Structure
- **Package `serial_pkg`** holds:
  - FSM state encodings (shared by TX and RX).
  - Default constants: `CLKS_PER_BIT`, `FIFO_DEPTH`.
  - The bit-count width.
- **Sub-module `byte_fifo`** (8-bit, parameterised depth, push/pop/full/empty/count) is instantiated twice.
- The TX and RX FSMs stay inline in `serial_endpoint`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Reset:** after reset, `uart_tx_out`=1, `proc_wready`=1, `proc_rvalid`=0, flags=0.
- **Single TX:** write 0xA5 → `uart_tx_out` sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Each level lasts 4 cycles; the start bit begins 1 edge after the write.
- **TX full:** 6 back-to-back writes 0x01..0x06 → `proc_wready` falls after the 5th (1 in FSM + 4 in FIFO). The 6th is dropped; 5 frames appear in order.
- **RX:** drive frame 0x3C → `proc_rvalid`=1 with `proc_rdata`=0x3C. One `proc_rden` pulse → `proc_rvalid`=0.
- **RX errors:**
  - Frame 0x55 with stop=0 → no byte, `rx_frame_err_out`=1.
  - 5 good frames with no reads → 4 bytes held, `rx_overrun_out`=1.
- **Glitch and reset mid-frame:**
  - 1-cycle low pulse on `uart_rx_in` → no byte, no flags.
  - `reset` low mid-TX-frame → `uart_tx_out`=1 without waiting for a clock edge.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial endpoint.
//   - UART FSM state encoding, used by both the TX and RX machines
//   - default bit period and FIFO depth
//   - data bit counter width
// Optional feature macro: SERIAL_ENDPOINT_PARITY_EN adds the PARITY state.
package serial_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200
  localparam int FIFO_DEPTH_DEFAULT   = 4;
  localparam int BIT_CNT_W            = 3;    // indexes 8 data bits

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_ENDPOINT_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/serial_endpoint_byte_fifo.sv
// byte_fifo: 8-bit first-word-fall-through FIFO.
// The head entry is read straight from the registered storage array.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
// Ports:
//   clock, reset     - clock, async active-low reset (empties FIFO, zeroes array)
//   push, wdata      - write request and data
//   pop              - remove head (ignored when empty)
//   rdata            - current head entry
//   full, empty      - status
//   count            - number of stored entries
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_endpoint.sv
// serial_endpoint: device side of the processor serial port.
// Processor bytes go through a TX FIFO onto a UART TX line; the UART RX line
// is deserialised into an RX FIFO that the processor pops.
// Ports:
//   clock, reset                    - clock, async active-low reset
//   uart_rx_in / uart_tx_out        - UART pins (idle high)
//   proc_rdata/proc_rvalid/proc_rden - RX FIFO head, non-empty, pop
//   proc_wdata/proc_wren/proc_wready - TX byte, push, not-full
//   rx_overrun_out, rx_frame_err_out - sticky RX error flags
// Optional feature macro: SERIAL_ENDPOINT_PARITY_EN (even parity, 8E1).
//
// state  | meaning
// IDLE   | line idle (TX: waiting for FIFO data, RX: waiting for low)
// START  | start bit (RX: half-bit wait then re-check)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (only with SERIAL_ENDPOINT_PARITY_EN)
// STOP   | stop bit
module serial_endpoint
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic [7:0] proc_rdata,
  output logic       proc_rvalid,
  input  logic       proc_rden,
  input  logic [7:0] proc_wdata,
  input  logic       proc_wren,
  output logic       proc_wready,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

  // ---------------- FIFOs ----------------
  logic [7:0]    tx_rdata;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_count;
  logic [7:0]    rx_shift;

  assign tx_push     = proc_wren && !tx_full;
  assign proc_wready = (tx_count != CW'(FIFO_DEPTH));
  assign rx_pop      = proc_rden && !rx_empty;
  assign proc_rvalid = (rx_count != '0);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),    .reset (reset),
    .push  (tx_push),  .wdata (proc_wdata), .pop   (tx_pop),
    .rdata (tx_rdata), .full  (tx_full),    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock (clock),      .reset (reset),
    .push  (rx_push),    .wdata (rx_shift), .pop   (rx_pop),
    .rdata (proc_rdata), .full  (rx_full),  .empty (rx_empty),
    .count (rx_count)
  );

  // ---------------- TX FSM ----------------
  uart_state_t            tx_state, tx_state_nxt;
  logic [TW-1:0]          tx_timer;
  logic [BIT_CNT_W-1:0]   tx_bit;
  logic [7:0]             tx_shift;
  logic                   tx_tc;

  assign tx_tc = (tx_timer == '0);
  // Popping at the end of STOP chains frames with no idle cycle between them.
  assign tx_pop = !tx_empty && ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_tc));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= ST_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_pop) tx_shift <= tx_rdata;
      // Held at the reload value in IDLE so START always gets a full period.
      if (tx_state == ST_IDLE || tx_tc) tx_timer <= BIT_LOAD;
      else                              tx_timer <= tx_timer - 1'b1;
      if (tx_state == ST_DATA && tx_tc) tx_bit <= tx_bit + 1'b1;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      ST_IDLE:   if (!tx_empty) tx_state_nxt = ST_START;
      ST_START:  if (tx_tc) tx_state_nxt = ST_DATA;
      ST_DATA:
        if (tx_tc && tx_bit == '1) begin
`ifdef SERIAL_ENDPOINT_PARITY_EN
          tx_state_nxt = ST_PARITY;
`else
          tx_state_nxt = ST_STOP;
`endif
        end
`ifdef SERIAL_ENDPOINT_PARITY_EN
      ST_PARITY: if (tx_tc) tx_state_nxt = ST_STOP;
`endif
      ST_STOP:   if (tx_tc) tx_state_nxt = tx_empty ? ST_IDLE : ST_START;
      default:   tx_state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from the state register, so reset forces the line high at once.
  always_comb begin
    uart_tx_out = 1'b1;
    case (tx_state)
      ST_START:  uart_tx_out = 1'b0;
      ST_DATA:   uart_tx_out = tx_shift[tx_bit];
`ifdef SERIAL_ENDPOINT_PARITY_EN
      ST_PARITY: uart_tx_out = ^tx_shift;
`endif
      default:   uart_tx_out = 1'b1;
    endcase
  end

  // ---------------- RX FSM ----------------
  uart_state_t            rx_state, rx_state_nxt;
  logic [TW-1:0]          rx_timer;
  logic [BIT_CNT_W-1:0]   rx_bit;
  logic                   rx_sync1, rx_sync2;
  logic                   rx_tc;
  logic                   rx_stop_smp;
  logic                   rx_par_ok;

  assign rx_tc       = (rx_timer == '0);
  assign rx_stop_smp = (rx_state == ST_STOP) && rx_tc;

`ifdef SERIAL_ENDPOINT_PARITY_EN
  logic rx_par_bad;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                             rx_par_bad <= 1'b0;
    else if (rx_state == ST_PARITY && rx_tc) rx_par_bad <= rx_sync2 ^ (^rx_shift);
  end
  assign rx_par_ok = !rx_par_bad;
`else
  assign rx_par_ok = 1'b1;
`endif

  assign rx_push = rx_stop_smp && rx_sync2 && rx_par_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_sync1         <= 1'b1;
      rx_sync2         <= 1'b1;
      rx_state         <= ST_IDLE;
      rx_timer         <= '0;
      rx_bit           <= '0;
      rx_shift         <= '0;
      rx_overrun_out   <= 1'b0;
      rx_frame_err_out <= 1'b0;
    end else begin
      rx_sync1 <= uart_rx_in;
      rx_sync2 <= rx_sync1;
      rx_state <= rx_state_nxt;
      // Half-bit wait first so every later sample lands mid-bit.
      if (rx_state == ST_IDLE) rx_timer <= HALF_LOAD;
      else if (rx_tc)          rx_timer <= BIT_LOAD;
      else                     rx_timer <= rx_timer - 1'b1;
      if (rx_state == ST_DATA && rx_tc) begin
        rx_shift <= {rx_sync2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_push && rx_full && !rx_pop)              rx_overrun_out   <= 1'b1;
      if (rx_stop_smp && (!rx_sync2 || !rx_par_ok))   rx_frame_err_out <= 1'b1;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      ST_IDLE:   if (!rx_sync2) rx_state_nxt = ST_START;
      ST_START:  if (rx_tc) rx_state_nxt = rx_sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (rx_tc && rx_bit == '1) begin
`ifdef SERIAL_ENDPOINT_PARITY_EN
          rx_state_nxt = ST_PARITY;
`else
          rx_state_nxt = ST_STOP;
`endif
        end
`ifdef SERIAL_ENDPOINT_PARITY_EN
      ST_PARITY: if (rx_tc) rx_state_nxt = ST_STOP;
`endif
      ST_STOP:   if (rx_tc) rx_state_nxt = ST_IDLE;
      default:   rx_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_endpoint.sv
module tb_serial_endpoint;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rx_in = 1'b1;
  logic       uart_tx_out;
  logic [7:0] proc_rdata;
  logic       proc_rvalid;
  logic       proc_rden = 1'b0;
  logic [7:0] proc_wdata = 8'h00;
  logic       proc_wren = 1'b0;
  logic       proc_wready;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int checks = 0;
  int failures = 0;

  serial_endpoint #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .proc_rdata       (proc_rdata),
    .proc_rvalid      (proc_rvalid),
    .proc_rden        (proc_rden),
    .proc_wdata       (proc_wdata),
    .proc_wren        (proc_wren),
    .proc_wready      (proc_wready),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected TX line levels: bit i is the i-th bit period (start, D0..D7, stop).
  typedef struct packed {
    logic [7:0] data;
    logic [9:0] bits;
  } tx_vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_ferr;
  } rx_vec_t;

  tx_vec_t tx_tab [4];
  rx_vec_t rx_tab [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_edges(2);
    reset = 1'b1;
    wait_edges(1);
  endtask

  task automatic do_write(input logic [7:0] b);
    proc_wdata = b;
    proc_wren  = 1'b1;
    wait_edges(1);
    proc_wren  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx_in = 1'b0;
    wait_edges(4);
    for (int k = 0; k < 8; k++) begin
      uart_rx_in = b[k];
      wait_edges(4);
    end
    uart_rx_in = stop_bit;
    wait_edges(4);
    uart_rx_in = 1'b1;
  endtask

  // Waits (bounded) for a start bit, decodes the frame mid-bit, returns the
  // byte and the number of cycles the line stayed idle before the start bit.
  task automatic recv_tx(output logic [7:0] b, output int gap);
    gap = 0;
    b = 8'h00;
    while (uart_tx_out !== 1'b0 && gap < 200) begin
      wait_edges(1);
      gap++;
    end
    check("tx_start_seen", {31'd0, uart_tx_out}, 32'd0);
    wait_edges(2);
    for (int k = 0; k < 8; k++) begin
      wait_edges(4);
      b[k] = uart_tx_out;
    end
    wait_edges(4);
    check("tx_stop_level", {31'd0, uart_tx_out}, 32'd1);
    wait_edges(2);
  endtask

  initial begin
    logic [7:0] got;
    int         gap;
    int         bad;

    tx_tab[0] = '{data: 8'hA5, bits: 10'b1101001010};
    tx_tab[1] = '{data: 8'h3C, bits: 10'b1001111000};
    tx_tab[2] = '{data: 8'h01, bits: 10'b1000000010};
    tx_tab[3] = '{data: 8'hFF, bits: 10'b1111111110};

    rx_tab[0] = '{data: 8'h3C, stop_bit: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    rx_tab[1] = '{data: 8'hA5, stop_bit: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    rx_tab[2] = '{data: 8'h55, stop_bit: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
    rx_tab[3] = '{data: 8'h00, stop_bit: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b1};

    // ---- reset state ----
    do_reset();
    check("rst_tx_line", {31'd0, uart_tx_out}, 32'd1);
    check("rst_wready",  {31'd0, proc_wready}, 32'd1);
    check("rst_rvalid",  {31'd0, proc_rvalid}, 32'd0);
    check("rst_rdata",   {24'd0, proc_rdata},  32'd0);
    check("rst_overrun", {31'd0, rx_overrun_out},   32'd0);
    check("rst_ferr",    {31'd0, rx_frame_err_out}, 32'd0);

    // ---- single TX frames, exact level and duration of every bit ----
    for (int v = 0; v < 4; v++) begin
      do_write(tx_tab[v].data);
      check("tx_latency_idle", {31'd0, uart_tx_out}, 32'd1);
      for (int k = 0; k < 10; k++) begin
        wait_edges(1);
        check("tx_bit_first", {31'd0, uart_tx_out}, {31'd0, tx_tab[v].bits[k]});
        wait_edges(3);
        check("tx_bit_last",  {31'd0, uart_tx_out}, {31'd0, tx_tab[v].bits[k]});
      end
      wait_edges(1);
      check("tx_back_idle", {31'd0, uart_tx_out}, 32'd1);
      wait_edges(3);
    end

    // ---- TX full: 6 back-to-back writes, 6th dropped ----
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          proc_wdata = 8'(i);
          proc_wren  = 1'b1;
          wait_edges(1);
          check("wready_fill", {31'd0, proc_wready}, (i < 5) ? 32'd1 : 32'd0);
        end
        proc_wren = 1'b0;
      end
      begin
        logic [7:0] fb;
        int         fg;
        for (int f = 0; f < 5; f++) begin
          recv_tx(fb, fg);
          check("tx_full_order", {24'd0, fb}, 32'(f + 1));
          if (f > 0) check("tx_back_to_back_gap", 32'(fg), 32'd0);
        end
      end
    join
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      wait_edges(1);
      if (uart_tx_out !== 1'b1) bad++;
    end
    check("tx_sixth_dropped", 32'(bad), 32'd0);
    check("wready_recovered", {31'd0, proc_wready}, 32'd1);

    // ---- RX table ----
    for (int v = 0; v < 4; v++) begin
      send_rx(rx_tab[v].data, rx_tab[v].stop_bit);
      check("rx_valid_before", {31'd0, proc_rvalid}, 32'd0);
      wait_edges(1);
      check("rx_valid_after", {31'd0, proc_rvalid}, {31'd0, rx_tab[v].exp_valid});
      check("rx_ferr", {31'd0, rx_frame_err_out}, {31'd0, rx_tab[v].exp_ferr});
      if (rx_tab[v].exp_valid) begin
        check("rx_data", {24'd0, proc_rdata}, {24'd0, rx_tab[v].data});
        proc_rden = 1'b1;
        wait_edges(1);
        proc_rden = 1'b0;
        check("rx_popped", {31'd0, proc_rvalid}, 32'd0);
      end
      wait_edges(4);
    end

    // ---- RX overrun: 5 frames, no reads ----
    for (int f = 0; f < 5; f++) begin
      send_rx(8'h11 + 8'(f), 1'b1);
      wait_edges(3);
      check("rx_overrun_progress", {31'd0, rx_overrun_out}, (f < 4) ? 32'd0 : 32'd1);
    end
    for (int f = 0; f < 4; f++) begin
      check("rx_overrun_valid", {31'd0, proc_rvalid}, 32'd1);
      check("rx_overrun_data", {24'd0, proc_rdata}, 32'h11 + 32'(f));
      proc_rden = 1'b1;
      wait_edges(1);
      proc_rden = 1'b0;
    end
    check("rx_overrun_drained", {31'd0, proc_rvalid}, 32'd0);
    proc_rden = 1'b1;
    wait_edges(1);
    proc_rden = 1'b0;
    check("rx_pop_empty_ignored", {31'd0, proc_rvalid}, 32'd0);

    // ---- reset clears sticky flags; glitch produces nothing ----
    do_reset();
    check("rst_clears_overrun", {31'd0, rx_overrun_out},   32'd0);
    check("rst_clears_ferr",    {31'd0, rx_frame_err_out}, 32'd0);
    uart_rx_in = 1'b0;
    wait_edges(1);
    uart_rx_in = 1'b1;
    wait_edges(20);
    check("glitch_no_byte", {31'd0, proc_rvalid},      32'd0);
    check("glitch_no_ferr", {31'd0, rx_frame_err_out}, 32'd0);
    check("glitch_no_ovr",  {31'd0, rx_overrun_out},   32'd0);

    // ---- reset mid TX frame: line goes high without a clock edge ----
    do_write(8'h00);
    wait_edges(6);
    check("tx_mid_frame_low", {31'd0, uart_tx_out}, 32'd0);
    #3;
    reset = 1'b0;
    #1;
    check("tx_async_reset_high", {31'd0, uart_tx_out}, 32'd1);
    #1;
    reset = 1'b1;
    wait_edges(8);
    check("tx_after_reset_idle", {31'd0, uart_tx_out}, 32'd1);

    // ---- reset mid RX frame: partial byte lost, no flags ----
    uart_rx_in = 1'b0;
    wait_edges(12);
    reset = 1'b0;
    wait_edges(1);
    uart_rx_in = 1'b1;
    reset = 1'b1;
    wait_edges(50);
    check("rx_partial_no_byte", {31'd0, proc_rvalid},      32'd0);
    check("rx_partial_no_ferr", {31'd0, rx_frame_err_out}, 32'd0);
    check("rx_partial_no_ovr",  {31'd0, rx_overrun_out},   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
